// File: rtl/clock_route_pkg.sv
// Shared types and default parameters for the clock-route enable requester.
package clock_route_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ENABLING,
    ST_ON,
    ST_DISABLING,
    ST_FAULT
  } state_t;

  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/clock_route_sync.sv
// Multi-flop level synchroniser bringing the remote-gate acknowledge into the requester clock.
module clock_route_sync #(
  parameter int STAGES = clock_route_pkg::DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) flops <= '0;
    else               flops <= {flops[STAGES-2:0], d};
  end

  assign q = flops[STAGES-1];

endmodule

// File: rtl/clock_route_enable_requester.sv
// Level-handshake requester that asks a remote clock gate to start or stop and times out stalled transitions.
//   state        | meaning
//   OFF          | gate stopped and acknowledged low
//   ENABLING     | enable raised, waiting for ack high
//   ON           | gate running, ack confirmed high
//   DISABLING    | enable dropped, waiting for ack low
//   FAULT        | transition timed out, waiting for timeout_clear
module clock_route_enable_requester
  import clock_route_pkg::*;
#(
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic req_enable,
  output logic async_enable,
  input  logic async_enable_ack,
  output logic status_enabled,
  output logic busy,
  output logic timeout_err,
  input  logic timeout_clear
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             enable_next;
  logic             ack_s;

  clock_route_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock        (clock),
    .async_resetn (async_resetn),
    .d            (async_enable_ack),
    .q            (ack_s)
  );

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state          <= ST_OFF;
      cnt            <= '0;
      async_enable   <= 1'b0;
      status_enabled <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      async_enable   <= enable_next;
      status_enabled <= (state_next == ST_ON);
      busy           <= (state_next == ST_ENABLING) || (state_next == ST_DISABLING);
      timeout_err    <= (state_next == ST_FAULT);
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    enable_next = async_enable;

    // Ack is tested before the terminal count so a same-edge ack never faults.
    case (state)
      ST_OFF: begin
        if (req_enable) state_next = ST_ENABLING;
        else if (ack_s) state_next = ST_DISABLING;
      end
      ST_ENABLING: begin
        if (ack_s)                  state_next = ST_ON;
        else if (cnt == CNT_TERM)   state_next = ST_FAULT;
      end
      ST_ON: begin
        if (!req_enable) state_next = ST_DISABLING;
        else if (!ack_s) state_next = ST_ENABLING;
      end
      ST_DISABLING: begin
        if (!ack_s)                 state_next = ST_OFF;
        else if (cnt == CNT_TERM)   state_next = ST_FAULT;
      end
      ST_FAULT: begin
        if (timeout_clear) state_next = ST_DISABLING;
      end
      default: state_next = ST_OFF;
    endcase

    if (state_next != state) begin
      cnt_next = '0;
    end else if ((state == ST_ENABLING || state == ST_DISABLING) && (cnt != '1)) begin
      cnt_next = cnt + 1'b1;
    end

    // FAULT keeps whatever level the faulting state was driving.
    case (state_next)
      ST_ENABLING, ST_ON:  enable_next = 1'b1;
      ST_OFF, ST_DISABLING: enable_next = 1'b0;
      default:             enable_next = async_enable;
    endcase
  end

endmodule

// File: tb/tb_clock_route_enable_requester.sv
// Directed and randomised checks of the clock-route enable requester against a cycle-level handshake model.
module tb_clock_route_enable_requester;

  localparam int SYNC    = 2;
  localparam int TIMEOUT = 16;

  localparam int M_OFF   = 0;
  localparam int M_EN    = 1;
  localparam int M_ON    = 2;
  localparam int M_DIS   = 3;
  localparam int M_FAULT = 4;

  logic clock = 1'b0;
  logic async_resetn;
  logic req_enable;
  logic async_enable;
  logic async_enable_ack;
  logic status_enabled;
  logic busy;
  logic timeout_err;
  logic timeout_clear;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int   m_state;
  int   m_age;
  logic m_ae;
  logic ms [SYNC];

  clock_route_enable_requester #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock            (clock),
    .async_resetn     (async_resetn),
    .req_enable       (req_enable),
    .async_enable     (async_enable),
    .async_enable_ack (async_enable_ack),
    .status_enabled   (status_enabled),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .timeout_clear    (timeout_clear)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = M_OFF;
    m_age   = 0;
    m_ae    = 1'b0;
    for (int i = 0; i < SYNC; i++) ms[i] = 1'b0;
  endfunction

  // Spec rules applied per edge; the remote ack is seen only after SYNC flops.
  function automatic void model_edge();
    logic acks;
    int   nxt;
    bit   expired;
    acks    = ms[SYNC-1];
    nxt     = m_state;
    expired = (m_age + 1 >= TIMEOUT);
    case (m_state)
      M_OFF:   if (req_enable) nxt = M_EN;  else if (acks)  nxt = M_DIS;
      M_EN:    if (acks)       nxt = M_ON;  else if (expired) nxt = M_FAULT;
      M_ON:    if (!req_enable) nxt = M_DIS; else if (!acks) nxt = M_EN;
      M_DIS:   if (!acks)      nxt = M_OFF; else if (expired) nxt = M_FAULT;
      default: if (timeout_clear) nxt = M_DIS;
    endcase
    if (nxt == M_EN || nxt == M_ON) m_ae = 1'b1;
    else if (nxt != M_FAULT)        m_ae = 1'b0;
    m_age   = (nxt != m_state) ? 0 : m_age + 1;
    m_state = nxt;
    for (int i = SYNC - 1; i > 0; i--) ms[i] = ms[i-1];
    ms[0] = async_enable_ack;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".async_enable"},   async_enable,   m_ae);
    chk({tag, ".status_enabled"}, status_enabled, m_state == M_ON);
    chk({tag, ".busy"},           busy,           (m_state == M_EN) || (m_state == M_DIS));
    chk({tag, ".timeout_err"},    timeout_err,    m_state == M_FAULT);
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    if (!async_resetn) model_reset();
    else               model_edge();
    cyc++;
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    async_resetn     = 1'b0;
    req_enable       = 1'b0;
    async_enable_ack = 1'b0;
    timeout_clear    = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    chk("reset.busy_const", busy, 1'b0);
    ticks("reset_hold", 2);
    async_resetn = 1'b1;

    // Enable: ack rises 5 cycles after the request is sampled.
    req_enable = 1'b1;
    tick("en");
    chk("en.ae_cycle1", async_enable, 1'b1);
    chk("en.busy_cycle1", busy, 1'b1);
    ticks("en_wait", 4);
    async_enable_ack = 1'b1;
    ticks("en_sync", 2);
    chk("en.status_before", status_enabled, 1'b0);
    chk("en.busy_before", busy, 1'b1);
    tick("en_on");
    chk("en.status_at_8", status_enabled, 1'b1);
    chk("en.busy_at_8", busy, 1'b0);

    // Disable: ack falls 3 cycles after enable drops.
    req_enable = 1'b0;
    tick("dis");
    chk("dis.ae_next_edge", async_enable, 1'b0);
    chk("dis.status", status_enabled, 1'b0);
    ticks("dis_wait", 2);
    async_enable_ack = 1'b0;
    ticks("dis_sync", SYNC + 1);
    chk("dis.busy_off", busy, 1'b0);
    chk("dis.err", timeout_err, 1'b0);

    // Timeout: ack never rises.
    req_enable = 1'b1;
    tick("to_enter");
    ticks("to_wait", TIMEOUT - 1);
    chk("to.no_fault_yet", timeout_err, 1'b0);
    tick("to_fault");
    chk("to.err", timeout_err, 1'b1);
    chk("to.ae_hold", async_enable, 1'b1);
    chk("to.busy", busy, 1'b0);
    req_enable = 1'b0;
    ticks("to_stay", 3);
    chk("to.sticky", timeout_err, 1'b1);
    timeout_clear = 1'b1;
    tick("to_clear");
    timeout_clear = 1'b0;
    chk("to.clear_err", timeout_err, 1'b0);
    chk("to.clear_ae", async_enable, 1'b0);
    chk("to.clear_busy", busy, 1'b1);
    ticks("to_off", 2);

    // Request toggles during ENABLING are ignored.
    req_enable = 1'b1;
    tick("tog_enter");
    async_enable_ack = 1'b1;
    req_enable = 1'b0;
    tick("tog_0");
    chk("tog.busy_a", busy, 1'b1);
    req_enable = 1'b1;
    tick("tog_1");
    chk("tog.busy_b", busy, 1'b1);
    tick("tog_on");
    chk("tog.on", status_enabled, 1'b1);
    ticks("tog_hold", 2);
    req_enable = 1'b0;
    tick("tog_dis");
    chk("tog.dis_ae", async_enable, 1'b0);
    async_enable_ack = 1'b0;
    ticks("tog_off", SYNC + 1);

    // Ack dropout while ON.
    req_enable = 1'b1;
    async_enable_ack = 1'b1;
    ticks("drop_up", SYNC + 2);
    chk("drop.on", status_enabled, 1'b1);
    async_enable_ack = 1'b0;
    ticks("drop_fall", SYNC + 1);
    chk("drop.status_low", status_enabled, 1'b0);
    chk("drop.reenabling", busy, 1'b1);
    ticks("drop_low", 10 - (SYNC + 1));
    async_enable_ack = 1'b1;
    ticks("drop_return", SYNC + 1);
    chk("drop.back_on", status_enabled, 1'b1);
    chk("drop.no_fault", timeout_err, 1'b0);

    // Reset in the middle of DISABLING with ack still high.
    req_enable = 1'b0;
    tick("rst_dis");
    #2;
    async_resetn = 1'b0;
    model_reset();
    #1;
    check_all("rst_now");
    chk("rst.ae", async_enable, 1'b0);
    chk("rst.busy", busy, 1'b0);
    #1;
    async_resetn = 1'b1;
    ticks("rst_resync", SYNC);
    chk("rst.still_off", busy, 1'b0);
    tick("rst_spurious");
    chk("rst.dis_entered", busy, 1'b1);
    async_enable_ack = 1'b0;
    ticks("rst_off", SYNC + 1);
    chk("rst.off", busy, 1'b0);

    // Randomised traffic against a remote gate that follows enable with random lag.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) req_enable = ~req_enable;
      if ($urandom_range(0, 3) == 0)  async_enable_ack = m_ae;
      if ($urandom_range(0, 59) == 0) async_enable_ack = ~async_enable_ack;
      timeout_clear = ($urandom_range(0, 7) == 0);
      if (i == 300) begin
        #2;
        async_resetn = 1'b0;
        model_reset();
        #1;
        check_all("rand_rst");
        async_resetn = 1'b1;
      end
      tick("rand");
    end
    timeout_clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
